// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the core's single memory port between instruction fetch and data
//   loads/stores. Data wins by default; after STARVE_LIMIT consecutive data
//   grants with a fetch waiting, the fetch is forced through. Each access
//   produces a one-cycle response pulse to its requester.
//
// Ports
//   CLK, RST                  clock, asynchronous active-high reset
//   fetch_req/fetch_addr      fetch request and address
//   fetch_valid/fetch_instr   fetch response pulse and instruction word
//   data_en/data_addr         data access request and byte address
//   store_size/store_data     00 byte, 01 half, 10 word store, 11 load
//   mem_read_data_valid       load response pulse, data on mem_read_data
//   mem_write_ready           store completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory request side
//   mem_ack/mem_rdata                          memory completion side
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned AW           = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          fetch_req,
   input  logic [AW-1:0] fetch_addr,
   output logic          fetch_valid,
   output logic [31:0]   fetch_instr,
   input  logic          data_en,
   input  logic [AW-1:0] data_addr,
   input  logic [1:0]    store_size,
   input  logic [31:0]   store_data,
   output logic          mem_read_data_valid,
   output logic [31:0]   mem_read_data,
   output logic          mem_write_ready,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {StIdle, StFetch, StDread, StDwrite, StResp} state_e;

   state_e          state_q;
   logic [CW-1:0]   starve_cnt_q;
   logic [CW-1:0]   starve_cnt_d;

   logic            grant_data;
   logic            grant_fetch;
   logic [AW-1:0]   sel_addr;
   logic [1:0]      sel_size;
   logic [3:0]      be_d;
   logic [31:0]     wdata_d;
   state_e          grant_state;

   // Grant decision and the memory-side image of the granted request.
   always_comb begin
      grant_data   = data_en && (!fetch_req || (starve_cnt_q < CW'(STARVE_LIMIT)));
      grant_fetch  = fetch_req && !grant_data;
      sel_addr     = grant_data ? data_addr : fetch_addr;
      // A fetch is encoded as a load so it shares the read path below.
      sel_size     = grant_data ? store_size : 2'b11;
      be_d         = 4'b1111;
      wdata_d      = '0;
      unique case (sel_size)
         2'b00: begin
            be_d    = 4'b0001 << sel_addr[1:0];
            wdata_d = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << {sel_addr[1], 1'b0};
            wdata_d = {2{store_data[15:0]}};
         end
         2'b10: begin
            wdata_d = store_data;
         end
         default: ;
      endcase

      if (!grant_data) begin
         grant_state = StFetch;
      end else if (sel_size == 2'b11) begin
         grant_state = StDread;
      end else begin
         grant_state = StDwrite;
      end

      starve_cnt_d = starve_cnt_q;
      if (grant_data && fetch_req) begin
         if (starve_cnt_q < CW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
         end
      end else if (grant_data || grant_fetch) begin
         starve_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q             <= StIdle;
         starve_cnt_q        <= '0;
         fetch_valid         <= 1'b0;
         fetch_instr         <= '0;
         mem_read_data_valid <= 1'b0;
         mem_read_data       <= '0;
         mem_write_ready     <= 1'b0;
         mem_req             <= 1'b0;
         mem_we              <= 1'b0;
         mem_addr            <= '0;
         mem_wdata           <= '0;
         mem_be              <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_data || grant_fetch) begin
                  state_q      <= grant_state;
                  starve_cnt_q <= starve_cnt_d;
                  mem_req      <= 1'b1;
                  mem_we       <= (sel_size != 2'b11);
                  mem_addr     <= {sel_addr[AW-1:2], 2'b00};
                  mem_be       <= be_d;
                  mem_wdata    <= wdata_d;
               end
            end
            StFetch: begin
               if (mem_ack) begin
                  state_q     <= StResp;
                  fetch_instr <= mem_rdata;
                  fetch_valid <= 1'b1;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
               end
            end
            StDread: begin
               if (mem_ack) begin
                  state_q             <= StResp;
                  mem_read_data       <= mem_rdata;
                  mem_read_data_valid <= 1'b1;
                  mem_req             <= 1'b0;
                  mem_we              <= 1'b0;
               end
            end
            StDwrite: begin
               if (mem_ack) begin
                  state_q         <= StResp;
                  mem_write_ready <= 1'b1;
                  mem_req         <= 1'b0;
                  mem_we          <= 1'b0;
               end
            end
            StResp: begin
               state_q             <= StIdle;
               fetch_valid         <= 1'b0;
               mem_read_data_valid <= 1'b0;
               mem_write_ready     <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple wait-state memory model.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic        data_en = 1'b0;
   logic [31:0] data_addr = '0;
   logic [1:0]  store_size = 2'b11;
   logic [31:0] store_data = '0;
   logic        mem_read_data_valid;
   logic [31:0] mem_read_data;
   logic        mem_write_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata = '0;

   int          ack_wait = 0;
   int          req_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.STARVE_LIMIT(8), .AW(32)) dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .fetch_req           (fetch_req),
      .fetch_addr          (fetch_addr),
      .fetch_valid         (fetch_valid),
      .fetch_instr         (fetch_instr),
      .data_en             (data_en),
      .data_addr           (data_addr),
      .store_size          (store_size),
      .store_data          (store_data),
      .mem_read_data_valid (mem_read_data_valid),
      .mem_read_data       (mem_read_data),
      .mem_write_ready     (mem_write_ready),
      .mem_req             (mem_req),
      .mem_we              (mem_we),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_be              (mem_be),
      .mem_ack             (mem_ack),
      .mem_rdata           (mem_rdata)
   );

   // Memory model: ack after ack_wait wait cycles of mem_req; reset with the core.
   assign mem_ack = mem_req && !RST && (req_cnt == ack_wait);
   always @(posedge CLK or posedge RST) begin
      if (RST) req_cnt <= 0;
      else if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access; checks grant image, latency, req length, pulse and data.
   task automatic access(input string tag, input logic is_fetch, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] sdata, input int wait_n,
                         input logic drop_early, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic exp_we,
                         input logic [31:0] exp_wdata, input logic [31:0] rdata);
      int          cyc;
      int          reqlen;
      logic        found;
      logic [2:0]  exp_pulse;
      logic [2:0]  pulses;
      @(posedge CLK);
      #1;
      ack_wait  = wait_n;
      mem_rdata = rdata;
      if (is_fetch) begin
         fetch_req  = 1'b1;
         fetch_addr = addr;
         exp_pulse  = 3'b100;
      end else begin
         data_en    = 1'b1;
         data_addr  = addr;
         store_size = size;
         store_data = sdata;
         exp_pulse  = (size == 2'b11) ? 3'b010 : 3'b001;
      end
      cyc    = 0;
      reqlen = 0;
      found  = 1'b0;
      pulses = 3'b000;
      while (cyc < 30 && !found) begin
         @(negedge CLK);
         cyc++;
         if (mem_req) reqlen++;
         pulses = {fetch_valid, mem_read_data_valid, mem_write_ready};
         if (cyc == 1) check_eq({tag, "_pre_req"}, {31'd0, mem_req}, 32'd0);
         if (cyc == 2) begin
            check_eq({tag, "_addr"}, mem_addr, exp_addr);
            check_eq({tag, "_be_we"}, {27'd0, mem_be, mem_we}, {27'd0, exp_be, exp_we});
            check_eq({tag, "_wdata"}, mem_wdata, exp_wdata);
            if (drop_early) begin
               fetch_req = 1'b0;
               data_en   = 1'b0;
            end
         end
         if (pulses != 3'b000) found = 1'b1;
      end
      check_eq({tag, "_latency"}, cyc, wait_n + 3);
      check_eq({tag, "_reqlen"}, reqlen, wait_n + 1);
      check_eq({tag, "_pulse"}, {29'd0, pulses}, {29'd0, exp_pulse});
      if (is_fetch) check_eq({tag, "_instr"}, fetch_instr, rdata);
      else if (size == 2'b11) check_eq({tag, "_rdata"}, mem_read_data, rdata);
      fetch_req = 1'b0;
      data_en   = 1'b0;
      @(negedge CLK);
      check_eq({tag, "_after"}, {28'd0, fetch_valid, mem_read_data_valid, mem_write_ready,
                                 mem_req}, 32'd0);
   endtask

   initial begin
      int          seq[$];
      int          guard;
      logic        seen;

      // Reset state.
      #2;
      check_eq("rst_ctrl", {26'd0, fetch_valid, mem_read_data_valid, mem_write_ready, mem_req,
                            mem_we, 1'b0}, 32'd0);
      check_eq("rst_buses", mem_addr | mem_wdata | {28'd0, mem_be} | fetch_instr | mem_read_data,
               32'd0);
      @(negedge CLK);
      RST = 1'b0;

      access("load", 1'b0, 2'b11, 32'h106, 32'h0, 0, 1'b0, 32'h104, 4'b1111, 1'b0, 32'h0,
             32'hDEADBEEF);
      access("sb", 1'b0, 2'b00, 32'h203, 32'h000000A5, 4, 1'b0, 32'h200, 4'b1000, 1'b1,
             32'hA5A5A5A5, 32'h0);
      access("sh", 1'b0, 2'b01, 32'h012, 32'h00001234, 1, 1'b0, 32'h010, 4'b1100, 1'b1,
             32'h12341234, 32'h0);
      access("sw", 1'b0, 2'b10, 32'h3FD, 32'hCAFEF00D, 0, 1'b0, 32'h3FC, 4'b1111, 1'b1,
             32'hCAFEF00D, 32'h0);
      access("sb0", 1'b0, 2'b00, 32'h201, 32'h123456C3, 0, 1'b0, 32'h200, 4'b0010, 1'b1,
             32'hC3C3C3C3, 32'h0);
      access("fetch_wd", 1'b1, 2'b11, 32'h43, 32'h0, 2, 1'b1, 32'h40, 4'b1111, 1'b0, 32'h0,
             32'h00000013);

      // Fetch and data both held high: 8 data grants, then the fetch, then data.
      @(posedge CLK);
      #1;
      ack_wait   = 0;
      fetch_req  = 1'b1;
      fetch_addr = 32'h80;
      data_en    = 1'b1;
      data_addr  = 32'h300;
      store_size = 2'b10;
      store_data = 32'h55AA55AA;
      guard      = 0;
      while (seq.size() < 10 && guard < 200) begin
         @(negedge CLK);
         guard++;
         if (fetch_valid) seq.push_back(1);
         if (mem_write_ready) seq.push_back(0);
      end
      fetch_req = 1'b0;
      data_en   = 1'b0;
      check_eq("starve_count", seq.size(), 10);
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("starve_order_%0d", i), (i < seq.size()) ? seq[i] : -1,
                  (i == 8) ? 1 : 0);
      end
      repeat (4) @(negedge CLK);

      // Reset while a load is waiting on memory.
      @(posedge CLK);
      #1;
      ack_wait   = 10;
      mem_rdata  = 32'hBAD0BAD0;
      data_en    = 1'b1;
      data_addr  = 32'h500;
      store_size = 2'b11;
      repeat (3) @(negedge CLK);
      check_eq("mid_req", {31'd0, mem_req}, 32'd1);
      RST = 1'b1;
      #1;
      check_eq("mid_rst_ctrl", {28'd0, fetch_valid, mem_read_data_valid, mem_write_ready,
                                mem_req}, 32'd0);
      check_eq("mid_rst_buses", mem_addr | mem_wdata | {28'd0, mem_be} | {31'd0, mem_we}
               | mem_read_data | fetch_instr, 32'd0);
      data_en = 1'b0;
      @(negedge CLK);
      RST  = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         if (mem_read_data_valid || mem_req) seen = 1'b1;
      end
      check_eq("no_resp_after_rst", {31'd0, seen}, 32'd0);

      access("post_rst_load", 1'b0, 2'b11, 32'h8, 32'h0, 0, 1'b0, 32'h8, 4'b1111, 1'b0, 32'h0,
             32'h0BADF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and data accesses (loads/stores).
- Generates the `mem_read_data_valid` and `mem_write_ready` handshakes that the main controller uses to release its load/store stall.
- Translates `store_size` into byte enables and lane-replicated write data.
- Sits between the fetch unit, the core's data path/controller, and the external memory interface.

Parameters:
- STARVE_LIMIT, 8: number of consecutive data grants allowed while a fetch is pending before fetch is forced to win the next grant.
- AW, 32: address width.

Ports:
- CLK  in  1  core clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- fetch_req  in  1  fetch unit requests an instruction word.
- fetch_addr  in  AW  fetch address; bits [1:0] are ignored.
- fetch_valid  out  1  one-cycle pulse; `fetch_instr` is valid.
- fetch_instr  out  32  fetched instruction word.
- data_en  in  1  data access request (controller `memory_en`).
- data_addr  in  AW  data byte address.
- store_size  in  2  00 = byte store, 01 = half store, 10 = word store, 11 = load.
- store_data  in  32  store data, right-aligned.
- mem_read_data_valid  out  1  one-cycle pulse; load data is valid.
- mem_read_data  out  32  raw aligned word returned for a load.
- mem_write_ready  out  1  one-cycle pulse; store has completed.
- mem_req  out  1  memory request; held until `mem_ack`.
- mem_we  out  1  1 = write.
- mem_addr  out  AW  word-aligned address, {addr[AW-1:2], 2'b00}.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory completed the request this cycle; `mem_rdata` is valid in the same cycle for reads.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset: state = IDLE, `starve_cnt` = 0. All outputs are 0, including data buses. Reset takes effect immediately (asynchronous).
- FSM states: IDLE, FETCH, DREAD, DWRITE, RESP.
- IDLE: samples the requests.
  - If `data_en` and (`!fetch_req` or `starve_cnt` < STARVE_LIMIT): go to DREAD when `store_size`==11, otherwise DWRITE.
  - Else if `fetch_req`: go to FETCH.
  - Else: stay in IDLE.
  - The address, `store_size` and `store_data` of the granted requester are registered on the grant edge.
- Starvation counter:
  - On a data grant while `fetch_req` is high: `starve_cnt` += 1, saturating at STARVE_LIMIT.
  - On a fetch grant, or a data grant with `fetch_req` low: `starve_cnt` = 0.
- FETCH, DREAD, DWRITE:
  - `mem_req` = 1; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are driven from the registered values and held stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata` (FETCH/DREAD only) and go to RESP.
  - `mem_req` deasserts in the cycle after the ack.
- RESP (exactly one cycle), then IDLE:
  - FETCH origin: `fetch_valid` = 1.
  - DREAD origin: `mem_read_data_valid` = 1.
  - DWRITE origin: `mem_write_ready` = 1.
  - Data outputs hold the captured word until the next capture.
- Timing:
  - Minimum latency from a request sampled in IDLE to the response pulse is 3 cycles (grant edge, ack in the first cycle of `mem_req`, RESP).
  - Back-to-back accesses are separated by one IDLE cycle.
- Byte enables and write data:
  - store_size 00: `mem_be` = 4'b0001 << addr[1:0]; `mem_wdata` = store_data[7:0] replicated 4x.
  - store_size 01: `mem_be` = 4'b0011 << {addr[1], 1'b0}; `mem_wdata` = store_data[15:0] replicated 2x. addr[0] is ignored (misaligned halves are not supported).
  - store_size 10: `mem_be` = 4'b1111; `mem_wdata` = store_data.
  - Loads and fetches: `mem_we` = 0, `mem_be` = 4'b1111, `mem_wdata` = 0.
- Request withdrawal: if a request drops mid-transaction, the memory transaction still completes and the RESP pulse is still issued.
- A request still high in IDLE after its RESP is treated as a new access. The controller deasserts or changes `data_en` on the response edge.
- Reset mid-transaction: the transaction is abandoned, no response pulse is issued, and the FSM returns to IDLE. The memory is reset alongside.
- `mem_ack` outside FETCH, DREAD and DWRITE is ignored.

Test Plan:
- Load: `data_en`=1, `store_size`=11, `data_addr`=0x106, memory acks in the 1st cycle with 0xDEADBEEF → `mem_addr`=0x104, `mem_be`=1111, `mem_we`=0; `mem_read_data_valid` pulses 1 cycle at cycle 3 with `mem_read_data`=0xDEADBEEF.
- Byte store: `store_size`=00, `data_addr`=0x203, `store_data`=0x000000A5, ack after 4 wait cycles → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5; `mem_req` is held for 5 cycles; `mem_write_ready` pulses once.
- Half store: `store_size`=01, addr=0x012, `store_data`=0x1234 → `mem_be`=1100, `mem_wdata`=0x12341234.
- Simultaneous requests: `fetch_req` and `data_en` held high continuously, STARVE_LIMIT=8 → grant order is 8 data accesses, 1 fetch, then data again; `fetch_valid` fires after the 8th `mem_write_ready`/`mem_read_data_valid` pulse.
- Withdrawal and reset: `fetch_req` dropped one cycle after grant → `fetch_valid` still pulses. `RST` pulsed while in DREAD → all outputs 0 immediately, no `mem_read_data_valid`, and a new request is served normally afterwards.
